// File: rtl/stack_tracked_pkg.sv
// Shared definitions for the tracked shift-register stack.
// Contents:
//   delta_e      stack-pointer move encodings (DELTA_W = 2) used by the CPU decode
//   FillDefault  default fill word for empty slots and reset contents
//   delta_is_pop helper: true when an encoded delta moves the pointer down
package stack_tracked_pkg;

  // Two's complement encodings of the signed pointer move.
  typedef enum logic [1:0] {
    DeltaNop  = 2'b00,  //  0
    DeltaPush = 2'b01,  // +1
    DeltaPop2 = 2'b10,  // -2
    DeltaPop  = 2'b11   // -1
  } delta_e;

  localparam logic [15:0] FillDefault = 16'h5AA5;

  function automatic logic delta_is_pop(input logic [1:0] delta);
    return delta[1];
  endfunction

endpackage

// File: rtl/stack_tracked_if.sv
// Operation/status bundle between the CPU decode (master) and the stack (slave).
// Signals:
//   we, delta, wd, clr_err   operation request (master -> slave)
//   rd1, rd2, rd3            top three entries (slave -> master)
//   depth, empty, full       occupancy status (slave -> master)
//   ovf, udf                 sticky misuse flags (slave -> master)
interface stack_tracked_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DELTA_W = 2
);
  localparam int unsigned DepthW = $clog2(DEPTH + 1);

  logic               we;
  logic [DELTA_W-1:0] delta;
  logic [WIDTH-1:0]   wd;
  logic               clr_err;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic [WIDTH-1:0]   rd3;
  logic [DepthW-1:0]  depth;
  logic               empty;
  logic               full;
  logic               ovf;
  logic               udf;

  modport master (
    output we, delta, wd, clr_err,
    input  rd1, rd2, rd3, depth, empty, full, ovf, udf
  );

  modport slave (
    input  we, delta, wd, clr_err,
    output rd1, rd2, rd3, depth, empty, full, ovf, udf
  );

endinterface

// File: rtl/stack_depth_track.sv
// Occupancy tracker for the shift-register stack: saturating depth counter,
// full/empty status and sticky overflow/underflow flags. All outputs registered.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   delta_i       signed pointer move (two's complement)
//   clr_err_i     clear sticky flags (a same-cycle new error keeps the flag set)
//   depth_o       occupancy 0..DEPTH
//   empty_o       depth == 0
//   full_o        depth == DEPTH
//   ovf_o, udf_o  sticky overflow / underflow
module stack_depth_track #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DELTA_W = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DELTA_W-1:0]             delta_i,
  input  logic                           clr_err_i,
  output logic [$clog2(DEPTH+1)-1:0]     depth_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic                           ovf_o,
  output logic                           udf_o
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  // Two guard bits: one for the sign, one so depth + max push cannot wrap.
  localparam int unsigned SW = DW + 2;
  localparam logic signed [SW-1:0] DepthMax = SW'(DEPTH);

  logic [DW-1:0] depth_q, depth_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic signed [SW-1:0] cur_s, dlt_s, nxt_s;
  logic                 ovf_set, udf_set;

  always_comb begin
    cur_s   = signed'({2'b00, depth_q});
    dlt_s   = signed'({{(SW - DELTA_W){delta_i[DELTA_W-1]}}, delta_i});
    nxt_s   = cur_s + dlt_s;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    depth_d = nxt_s[DW-1:0];
    if (nxt_s > DepthMax) begin
      ovf_set = 1'b1;
      depth_d = DW'(DEPTH);
    end else if (nxt_s[SW-1]) begin
      udf_set = 1'b1;
      depth_d = '0;
    end
    empty_d = (depth_d == '0);
    full_d  = (depth_d == DW'(DEPTH));
    // A new error in the clearing cycle wins over the clear.
    ovf_d   = (ovf_q & ~clr_err_i) | ovf_set;
    udf_d   = (udf_q & ~clr_err_i) | udf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign depth_o = depth_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: rtl/stack_tracked.sv
// Parametrised shift-register stack for the J1-style data/return stacks.
// Signed multi-entry pointer move, write-on-top, three read taps, and a live
// occupancy tracker with sticky misuse flags. Every output comes from a register.
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous reset, active high, beats any concurrent operation
//   bus   slave side of stack_tracked_if (op request in, taps and status out)
module stack_tracked
  import stack_tracked_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      DEPTH   = 16,
  parameter int unsigned      DELTA_W = 2,
  parameter logic [WIDTH-1:0] FILL    = WIDTH'(FillDefault)
) (
  input logic            clk,
  input logic            rst,
  stack_tracked_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (!((2 ** (DELTA_W - 1)) < DEPTH) || (DEPTH < 4)) begin : g_param_check
    $error("stack_tracked: need DEPTH >= 4 and 2**(DELTA_W-1) < DEPTH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  int               d_int;

  assign d_int = int'($signed(bus.delta));

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] shift_val;
    int               src;

    always_comb begin
      src       = i - d_int;
      shift_val = mem_q[i];
      if (d_int > 0) begin
        // Slots freed at the top duplicate the old top; bottom entries fall off.
        shift_val = (src >= 0) ? mem_q[src[AW-1:0]] : mem_q[0];
      end else if (d_int < 0) begin
        shift_val = (src < int'(DEPTH)) ? mem_q[src[AW-1:0]] : FILL;
      end
    end

    if (i == 0) begin : g_top
      assign mem_d[i] = bus.we ? bus.wd : shift_val;
    end else begin : g_rest
      assign mem_d[i] = shift_val;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[i] <= FILL;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.rd1 = mem_q[0];
  assign bus.rd2 = mem_q[1];
  assign bus.rd3 = mem_q[2];

  stack_depth_track #(
    .DEPTH   (DEPTH),
    .DELTA_W (DELTA_W)
  ) u_depth (
    .clk       (clk),
    .rst       (rst),
    .delta_i   (bus.delta),
    .clr_err_i (bus.clr_err),
    .depth_o   (bus.depth),
    .empty_o   (bus.empty),
    .full_o    (bus.full),
    .ovf_o     (bus.ovf),
    .udf_o     (bus.udf)
  );

endmodule

// File: tb/tb_stack_tracked.sv
module tb_stack_tracked;
  import stack_tracked_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned DW = 2;
  localparam logic [15:0] F  = 16'h5AA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  stack_tracked_if #(.WIDTH(W), .DEPTH(D), .DELTA_W(DW)) bus ();

  stack_tracked #(
    .WIDTH   (W),
    .DEPTH   (D),
    .DELTA_W (DW),
    .FILL    (F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  delta;
    logic [15:0] wd;
    logic        clr;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] rd3;
    logic [3:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        udf;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op(input logic r, input logic we, input logic [1:0] dl,
                    input logic [15:0] wd, input logic clr);
    rst         = r;
    bus.we      = we;
    bus.delta   = dl;
    bus.wd      = wd;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] r1, input logic [15:0] r2,
                           input logic [15:0] r3, input logic [3:0] dp, input logic em,
                           input logic fu, input logic ov, input logic ud);
    chk({tag, ".rd1"}, 32'(bus.rd1), 32'(r1));
    chk({tag, ".rd2"}, 32'(bus.rd2), 32'(r2));
    chk({tag, ".rd3"}, 32'(bus.rd3), 32'(r3));
    chk({tag, ".depth"}, 32'(bus.depth), 32'(dp));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(em));
    chk({tag, ".full"}, 32'(bus.full), 32'(fu));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(ov));
    chk({tag, ".udf"}, 32'(bus.udf), 32'(ud));
  endtask

  initial begin
    bus.we      = 1'b0;
    bus.delta   = DeltaNop;
    bus.wd      = '0;
    bus.clr_err = 1'b0;

    //         rst   we    delta      wd        clr   rd1       rd2      rd3      dp     em    fu    ov    ud
    vecs[0] = '{1'b1, 1'b0, DeltaNop,  16'h0,    1'b0, F,        F,       F,       4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, DeltaPush, 16'h1,    1'b0, 16'h1,    F,       F,       4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, DeltaPush, 16'h2,    1'b0, 16'h2,    16'h1,   F,       4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, DeltaPush, 16'h3,    1'b0, 16'h3,    16'h2,   16'h1,   4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, DeltaPop,  16'h0,    1'b0, 16'h2,    16'h1,   F,       4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, DeltaPush, 16'h7,    1'b0, 16'h7,    16'h2,   16'h1,   4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    // Dup of T, then replace T in place.
    vecs[6] = '{1'b0, 1'b0, DeltaPush, 16'h0,    1'b0, 16'h7,    16'h7,   16'h2,   4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, DeltaNop,  16'h9,    1'b0, 16'h9,    16'h7,   16'h2,   4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, DeltaPop2, 16'h0,    1'b0, 16'h2,    16'h1,   F,       4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    // Reset beats a concurrent push.
    vecs[9] = '{1'b1, 1'b1, DeltaPush, 16'hBEEF, 1'b0, F,        F,       F,       4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      op(vecs[i].rst, vecs[i].we, vecs[i].delta, vecs[i].wd, vecs[i].clr);
      chk_state($sformatf("v%0d", i), vecs[i].rd1, vecs[i].rd2, vecs[i].rd3, vecs[i].depth,
                vecs[i].empty, vecs[i].full, vecs[i].ovf, vecs[i].udf);
    end

    // Fill to exactly DEPTH: full but no overflow yet.
    for (int k = 1; k <= 8; k++) op(1'b0, 1'b1, DeltaPush, 16'(k), 1'b0);
    chk_state("fill8", 16'h8, 16'h7, 16'h6, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

    // Ninth push saturates depth and sets ovf; 1 falls off the bottom.
    op(1'b0, 1'b1, DeltaPush, 16'h9, 1'b0);
    chk_state("ovf", 16'h9, 16'h8, 16'h7, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);

    op(1'b0, 1'b0, DeltaNop, 16'h0, 1'b1);
    chk_state("clr_ovf", 16'h9, 16'h8, 16'h7, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

    // Drain to depth 1: remaining words are 9..2, so T ends at 2 with FILL beneath.
    for (int k = 0; k < 7; k++) begin
      op(1'b0, 1'b0, DeltaPop, 16'h0, 1'b0);
      chk($sformatf("drain%0d.rd1", k), 32'(bus.rd1), 32'(8 - k));
    end
    chk_state("depth1", 16'h2, F, F, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pop two from depth 1: clamps at 0 and flags underflow.
    op(1'b0, 1'b0, DeltaPop2, 16'h0, 1'b0);
    chk_state("udf", F, F, F, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Clear with a fresh underflow in the same cycle keeps the flag.
    op(1'b0, 1'b0, DeltaPop, 16'h0, 1'b1);
    chk_state("udf_hold", F, F, F, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    op(1'b0, 1'b0, DeltaNop, 16'h0, 1'b1);
    chk_state("udf_clr", F, F, F, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Push after clear, then reset mid-sequence discards everything.
    op(1'b0, 1'b1, DeltaPush, 16'hCAFE, 1'b0);
    chk_state("push_after", 16'hCAFE, F, F, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b1, 1'b0, DeltaNop, 16'h0, 1'b0);
    chk_state("rst_mid", F, F, F, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
